// File: rtl/pin_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_if
// Description : Keypad/locksys-side signal bundle for pin_entry.
// Revision    : 1.0 - initial release
// ============================================================================
interface pin_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alarm;
    logic [15:0] inpin;
    logic        enter;
    logic [2:0]  digit_count;
    logic        error;
    logic        locked;

    // master: keypad scanner plus locksys feedback; slave: pin_entry
    modport master (
        output key_valid, key_code, alarm,
        input  inpin, enter, digit_count, error, locked
    );
    modport slave (
        input  key_valid, key_code, alarm,
        output inpin, enter, digit_count, error, locked
    );
endinterface
`default_nettype wire

// File: rtl/pin_entry.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry
// Description : Keypad PIN collector with submit strobe, timeout and lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  wire logic  clk,
    input  wire logic  reset,
    pin_entry_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] c_LOCK    = LW'(LOCKOUT_CYCLES);
    localparam logic [3:0]    c_CLEAR   = 4'hE;
    localparam logic [3:0]    c_ENTER   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_FULL    = 3'd2,
        S_SUBMIT  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t        r_state;
    logic [15:0]   r_inpin;
    logic [2:0]    r_count;
    logic          r_enter;
    logic          r_error;
    logic          r_locked;
    logic [TW-1:0] r_idle;
    logic [LW-1:0] r_lock_cnt;

    logic w_digit;
    logic w_key_ok;

    // Codes 0xA-0xD never count as a key, so they cannot refresh the timeout
    assign w_digit  = bus.key_code <= 4'd9;
    assign w_key_ok = bus.key_valid &&
                      (w_digit || bus.key_code == c_CLEAR || bus.key_code == c_ENTER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_inpin    <= 16'h0000;
            r_count    <= 3'd0;
            r_enter    <= 1'b0;
            r_error    <= 1'b0;
            r_locked   <= 1'b0;
            r_idle     <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_enter <= 1'b0;
            r_error <= 1'b0;
            if (bus.alarm) begin
                r_state    <= S_LOCKOUT;
                r_lock_cnt <= c_LOCK;
                r_locked   <= 1'b1;
                r_inpin    <= 16'h0000;
                r_count    <= 3'd0;
                r_idle     <= '0;
            end else begin
                case (r_state)
                    S_LOCKOUT: begin
                        if (r_lock_cnt <= LW'(1)) begin
                            r_state    <= S_IDLE;
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt - LW'(1);
                        end
                    end
                    S_SUBMIT: begin
                        r_state <= S_IDLE;
                        r_inpin <= 16'h0000;
                        r_count <= 3'd0;
                        r_idle  <= '0;
                    end
                    default: begin
                        if (w_key_ok) begin
                            r_idle <= '0;
                            if (w_digit) begin
                                if (r_state != S_FULL) begin
                                    r_inpin <= {r_inpin[11:0], bus.key_code};
                                    r_count <= r_count + 3'd1;
                                    r_state <= (r_count == 3'd3) ? S_FULL : S_COLLECT;
                                end
                            end else if (bus.key_code == c_ENTER && r_state == S_FULL) begin
                                r_state <= S_SUBMIT;
                                r_enter <= 1'b1;
                            end else begin
                                // CLEAR, or ENTER before four digits (the latter flags an error)
                                r_error <= (bus.key_code == c_ENTER);
                                r_state <= S_IDLE;
                                r_inpin <= 16'h0000;
                                r_count <= 3'd0;
                            end
                        end else if (r_state == S_IDLE) begin
                            r_idle <= '0;
                        end else if (r_idle == c_TO_LAST) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                            r_inpin <= 16'h0000;
                            r_count <= 3'd0;
                            r_idle  <= '0;
                        end else begin
                            r_idle <= r_idle + TW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.inpin       = r_inpin;
    assign bus.enter       = r_enter;
    assign bus.digit_count = r_count;
    assign bus.error       = r_error;
    assign bus.locked      = r_locked;
endmodule
`default_nettype wire

// File: tb/tb_pin_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_entry
// Description : Scoreboard bench for pin_entry with a digit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_entry;
    localparam int c_T = 8;
    localparam int c_L = 4;

    typedef struct packed {
        logic [15:0] inpin;
        logic        enter;
        logic [2:0]  cnt;
        logic        err;
        logic        lk;
    } snap_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    snap_t exp_q[$];

    pin_entry_if bus ();

    pin_entry #(.TIMEOUT_CYCLES(c_T), .LOCKOUT_CYCLES(c_L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: digits held in a queue, PIN value computed arithmetically
    int  m_digs[$];
    bit  m_lk;
    int  m_lk_left;
    bit  m_sub;
    int  m_idle;

    initial begin
        forever begin
            snap_t s;
            bit    err;
            int    v;
            @(posedge clk or negedge reset);
            err = 0;
            if (!reset) begin
                m_digs = {};
                m_lk = 0; m_lk_left = 0; m_sub = 0; m_idle = 0;
                exp_q = {};
            end else if (bus.alarm) begin
                m_lk = 1; m_lk_left = c_L; m_digs = {}; m_sub = 0; m_idle = 0;
            end else if (m_lk) begin
                m_lk_left--;
                if (m_lk_left == 0) m_lk = 0;
            end else if (m_sub) begin
                m_sub = 0; m_digs = {}; m_idle = 0;
            end else if (bus.key_valid && (bus.key_code <= 9 || bus.key_code >= 14)) begin
                m_idle = 0;
                if (bus.key_code <= 9) begin
                    if (m_digs.size() < 4) m_digs.push_back(int'(bus.key_code));
                end else if (bus.key_code == 14) begin
                    m_digs = {};
                end else if (m_digs.size() == 4) begin
                    m_sub = 1;
                end else begin
                    m_digs = {}; err = 1;
                end
            end else if (m_digs.size() > 0) begin
                m_idle++;
                if (m_idle == c_T) begin
                    m_digs = {}; err = 1; m_idle = 0;
                end
            end
            v = 0;
            foreach (m_digs[i]) v = v * 16 + m_digs[i];
            s.inpin = 16'(v);
            s.enter = m_sub;
            s.cnt   = 3'(m_digs.size());
            s.err   = err;
            s.lk    = m_lk;
            exp_q.push_back(s);
        end
    end

    // Monitor: one snapshot per cycle, compared away from the active edge
    initial begin
        forever begin
            snap_t e;
            snap_t a;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.inpin, bus.enter, bus.digit_count, bus.error, bus.locked};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle@%0t: got inpin=%h enter=%b cnt=%0d err=%b lk=%b exp inpin=%h enter=%b cnt=%0d err=%b lk=%b",
                             $time, a.inpin, a.enter, a.cnt, a.err, a.lk,
                             e.inpin, e.enter, e.cnt, e.err, e.lk);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] c, input logic a);
        @(posedge clk);
        #1;
        bus.key_valid = v;
        bus.key_code  = c;
        bus.alarm     = a;
    endtask

    task automatic keys(input logic [3:0] c);
        cyc(1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        int al_left;
        int gap;
        logic v;
        logic [3:0] code;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.alarm     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Full PIN and submit
        keys(4'h1); keys(4'h2); keys(4'h3); keys(4'h4); keys(4'hF); idle(3);
        // Premature ENTER, then overflow digit ignored
        keys(4'h5); keys(4'h6); keys(4'hF); idle(2);
        keys(4'h1); keys(4'h2); keys(4'h3); keys(4'h4); keys(4'h7); idle(2);
        keys(4'hE); idle(1);
        // CLEAR and invalid code
        keys(4'h9); keys(4'h8); keys(4'hE); keys(4'hB); idle(2);
        // Timeout, and a key at idle cycle 7 restarting it
        keys(4'h3); idle(c_T + 2);
        keys(4'h3); idle(c_T - 1); keys(4'h4); idle(c_T + 2);
        // Alarm while digits held; keys ignored during lockout
        keys(4'h1); keys(4'h2);
        cyc(1'b1, 4'h5, 1'b1); cyc(1'b1, 4'h6, 1'b1); cyc(1'b0, 4'h0, 1'b1);
        keys(4'h7); keys(4'h8); keys(4'h9); keys(4'h1); keys(4'h2); idle(3);
        // Alarm coinciding with ENTER on FULL
        keys(4'h4); keys(4'h3); keys(4'h2); keys(4'h1); cyc(1'b1, 4'hF, 1'b1); idle(c_L + 2);
        // Alarm arriving during the submit cycle
        keys(4'h4); keys(4'h3); keys(4'h2); keys(4'h1); keys(4'hF); cyc(1'b0, 4'h0, 1'b1); idle(c_L + 2);

        // Asynchronous reset between edges with 0x0120 held
        keys(4'h1); keys(4'h2); keys(4'h0);
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        total++;
        if ({bus.inpin, bus.enter, bus.digit_count, bus.error, bus.locked} !== 22'd0) begin
            bad++;
            $display("FAIL async_reset: got inpin=%h cnt=%0d enter=%b err=%b lk=%b exp all zero",
                     bus.inpin, bus.digit_count, bus.enter, bus.error, bus.locked);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        keys(4'h1); keys(4'h2); keys(4'h3); keys(4'h4); keys(4'hF); idle(3);

        // Randomized traffic
        al_left = 0;
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (al_left == 0 && $urandom_range(0, 249) == 0) al_left = int'($urandom_range(1, 4));
            if (gap > 0) begin
                gap--;
                v = 1'b0;
            end else begin
                if ($urandom_range(0, 39) == 0) gap = int'($urandom_range(5, 12));
                v = 1'($urandom_range(0, 1));
            end
            code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) code = 4'($urandom_range(0, 9));
            cyc(v, code, al_left > 0);
            if (al_left > 0) al_left--;
        end
        idle(c_L + c_T + 4);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pin_entry.md
# pin_entry

Keypad-side front end for `locksys`. Collects a stream of 4-bit key codes from the keypad scanner, assembles four BCD digits MSB-first into the 16-bit `inpin` word and issues a single-cycle `enter` strobe on the confirm key. It also enforces an inactivity timeout and an alarm lockout window. Its `inpin`/`enter` outputs drive `locksys` directly, and `locksys.alarm` feeds back into `alarm`.

## Interface
- `TIMEOUT_CYCLES`, 1000: idle cycles mid-entry before the buffer is discarded (≥2).
- `LOCKOUT_CYCLES`, 5000: cycles keys are ignored after alarm deasserts (≥1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid with it.
- `key_code`  in  4  0x0–0x9 digit, 0xE CLEAR, 0xF ENTER, 0xA–0xD invalid.
- `alarm`  in  1  from `locksys`; level-sensitive.
- `inpin`  out  16  assembled PIN, digit 1 in [15:12].
- `enter`  out  1  one-cycle submit strobe to `locksys`.
- `digit_count`  out  3  digits held, 0–4.
- `error`  out  1  one-cycle pulse on a premature ENTER or a timeout.
- `locked`  out  1  high while in LOCKOUT.

## Operation
- States: IDLE (count 0), COLLECT (count 1–3), FULL (count 4), SUBMIT, LOCKOUT.
- Reset values: all outputs 0; state IDLE; idle and lockout counters 0.
- Digit key in IDLE or COLLECT:
  - `inpin <= {inpin[11:0], key_code}`; count increments.
  - Count reaching 4 moves to FULL.
- Digit key in FULL: ignored; `inpin` and count unchanged.
- ENTER key in FULL: go to SUBMIT.
- ENTER key in IDLE or COLLECT:
  - `inpin` and count cleared; `error` pulses; go to IDLE.
- CLEAR key in any non-LOCKOUT, non-SUBMIT state: `inpin` and count cleared; go to IDLE; no error.
- Codes 0xA–0xD: ignored everywhere, and do not reset the idle counter.
- SUBMIT lasts exactly one cycle:
  - `enter` = 1 with `inpin` stable.
  - Any key arriving in this cycle is dropped.
  - Next state IDLE, with `inpin` and count cleared.
- Timeout (COLLECT or FULL only):
  - The idle counter clears on any accepted key (digit/CLEAR/ENTER) and otherwise increments.
  - On reaching `TIMEOUT_CYCLES`: buffer cleared, `error` pulses, go to IDLE.
  - In IDLE the counter is held at 0.
- LOCKOUT:
  - Entered from any state on the first edge that samples `alarm` = 1. Buffer cleared; a pending SUBMIT is aborted and `enter` is not issued.
  - The lockout counter reloads to `LOCKOUT_CYCLES` every cycle `alarm` = 1 and decrements while `alarm` = 0.
  - Exits to IDLE on the edge where the counter reaches 0 with `alarm` = 0.
  - All keys are ignored while in LOCKOUT.
- Priority when events coincide: `alarm` > accepted key > timeout.

## Timing
- All outputs are registered. A key sampled at edge N is reflected in `inpin`, `digit_count`, `error` and `state` from edge N onward, i.e. visible in the cycle after N.
- ENTER sampled at edge N:
  - `enter` is high for the single cycle between edges N and N+1.
  - `inpin` holds the 4-digit value throughout that cycle.
  - At edge N+1, `inpin` returns to 0.
- `error` is high for exactly one cycle after the triggering edge.
- Timeout: a key at edge K followed by silence gives `error` after edge K+`TIMEOUT_CYCLES`.
- Lockout: `alarm` falling before edge A gives `locked` = 0 after edge A+`LOCKOUT_CYCLES`−1, and the first key is accepted at the next edge.
- Asynchronous `reset` assertion mid-operation forces the reset values immediately, independent of `clk`. Deassertion is synchronous to the next edge by the upstream reset synchronizer.

## Test plan
- Keys 1,2,3,4,ENTER on consecutive cycles → `inpin` = 0x1234 and `enter` = 1 for one cycle, then `inpin` = 0, `digit_count` = 0.
- Keys 5,6,ENTER → `error` pulses one cycle, `enter` stays 0, `inpin` = 0. Keys 1,2,3,4,7 → `inpin` stays 0x1234, `digit_count` = 4.
- Keys 9,8 then CLEAR → `inpin` = 0, `digit_count` = 0, no `error`. A following 0xB → no change.
- With `TIMEOUT_CYCLES` = 8: key 3, then 8 idle cycles → `error` one cycle, `inpin` = 0, state IDLE. A key at idle cycle 7 restarts the count.
- With `LOCKOUT_CYCLES` = 4: `alarm` high for 3 cycles with 1,2 held → `locked` = 1, `inpin` = 0, keys ignored. `locked` drops 4 cycles after `alarm` falls. `alarm` in the same cycle as ENTER on FULL → no `enter`.
- Assert `reset` low asynchronously between edges with `inpin` = 0x0120 → outputs go to 0 without waiting for a clock edge. After release, 1,2,3,4,ENTER works normally.
